// File: rtl/frame_sync_buffer.sv
// Double-banked channel buffer: the producer fills a staging bank, which is copied
// into the display bank only at the start of vertical blanking (commit-gated or free-run).
`timescale 1ns/1ps
module frame_sync_buffer #(
    parameter int unsigned    N_CH        = 16,
    parameter int unsigned    W           = 10,
    parameter int unsigned    AW          = 6,
    parameter logic [W-1:0]   INIT_VAL    = '0,
    parameter int unsigned    SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vs,
    input  logic                mode,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [W-1:0]        wr_data,
    input  logic                commit,
    output logic                wr_ready,
    output logic                pending,
    output logic [N_CH*W-1:0]   disp_data,
    output logic                swap_pulse,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         stale_cnt
);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [AW:0] NCH_L = (AW+1)'(N_CH);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] vs_sync_q;
    logic                   vs_hist_q;
    logic                   vblank_start;
    logic [W-1:0]           staging_q [N_CH];
    logic [N_CH*W-1:0]      disp_q;
    logic                   swap_q;
    logic [15:0]            frame_q;
    logic [15:0]            stale_q;
    logic                   do_swap;
    logic                   stale_inc;
    logic                   wr_ready_c;
    logic                   wr_ok;

    // Synchroniser idles high so a reset release with vs already low still yields one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync_q <= '1;
            vs_hist_q <= 1'b1;
        end else begin
            vs_sync_q <= {vs_sync_q[SYNC_STAGES-2:0], vs};
            vs_hist_q <= vs_sync_q[SYNC_STAGES-1];
        end
    end

    assign vblank_start = vs_hist_q & ~vs_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        do_swap    = 1'b0;
        stale_inc  = 1'b0;
        wr_ready_c = mode | (state_q == ST_OPEN);
        if (mode) begin
            state_d = ST_OPEN;
            do_swap = vblank_start;
        end else begin
            case (state_q)
                ST_OPEN: begin
                    if (commit) begin
                        state_d = ST_LOCKED;
                    end
                    stale_inc = vblank_start;
                end
                ST_LOCKED: begin
                    if (vblank_start) begin
                        do_swap = 1'b1;
                        state_d = ST_OPEN;
                    end
                end
                default: state_d = ST_OPEN;
            endcase
        end
    end

    assign wr_ok = wr_en & wr_ready_c & ({1'b0, wr_addr} < NCH_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                staging_q[i] <= INIT_VAL;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (wr_ok && (wr_addr == AW'(i))) begin
                    staging_q[i] <= wr_data;
                end
            end
        end
    end

    // The copy reads the pre-edge staging bank, so a same-cycle write lands next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= {N_CH{INIT_VAL}};
            swap_q <= 1'b0;
        end else begin
            swap_q <= do_swap;
            if (do_swap) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    disp_q[i*W +: W] <= staging_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            stale_q <= '0;
        end else begin
            if (do_swap) begin
                frame_q <= frame_q + 16'd1;
            end
            if (stale_inc && (stale_q != '1)) begin
                stale_q <= stale_q + 16'd1;
            end
        end
    end

    assign wr_ready   = wr_ready_c;
    assign pending    = ~mode & (state_q == ST_LOCKED);
    assign disp_data  = disp_q;
    assign swap_pulse = swap_q;
    assign frame_cnt  = frame_q;
    assign stale_cnt  = stale_q;

endmodule

// File: tb/tb_frame_sync_buffer.sv
// Directed bench for frame_sync_buffer: a reference staging model pushes expected
// display snapshots into a queue, which are popped when a swap is due.
`timescale 1ns/1ps
module tb_frame_sync_buffer;

    localparam int unsigned  N_CH = 16;
    localparam int unsigned  W    = 10;
    localparam int unsigned  AW   = 6;
    localparam int unsigned  SS   = 2;
    localparam int unsigned  DW   = N_CH * W;
    localparam logic [W-1:0] IV   = 10'd700;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vs;
    logic          mode;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          commit;
    logic          wr_ready;
    logic          pending;
    logic [DW-1:0] disp_data;
    logic          swap_pulse;
    logic [15:0]   frame_cnt;
    logic [15:0]   stale_cnt;

    frame_sync_buffer #(
        .N_CH        (N_CH),
        .W           (W),
        .AW          (AW),
        .INIT_VAL    (IV),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vs         (vs),
        .mode       (mode),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .wr_ready   (wr_ready),
        .pending    (pending),
        .disp_data  (disp_data),
        .swap_pulse (swap_pulse),
        .frame_cnt  (frame_cnt),
        .stale_cnt  (stale_cnt)
    );

    always #20 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [W-1:0]  stg [N_CH];
    logic [DW-1:0] m_disp;
    logic          m_locked;
    int unsigned   m_frame;
    int unsigned   m_stale;
    int unsigned   swaps_seen;

    function automatic logic [DW-1:0] pack_stg();
        logic [DW-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i*W +: W] = stg[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) stg[i] = IV;
        m_disp   = {N_CH{IV}};
        m_locked = 1'b0;
        m_frame  = 0;
        m_stale  = 0;
        exp_q.delete();
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_pending"}, DW'(pending), DW'(m_locked && !mode));
        chk({tag, "_wr_ready"}, DW'(wr_ready), DW'(mode || !m_locked));
    endtask

    // One staging-port cycle: optional write plus optional commit.
    task automatic port_cycle(input bit en, input logic [AW-1:0] a, input logic [W-1:0] d, input bit c);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        commit  = c;
        if (en && (mode || !m_locked) && (32'(a) < N_CH)) stg[a] = d;
        if (c && !mode && !m_locked) begin
            m_locked = 1'b1;
            exp_q.push_back(pack_stg());
        end
        tick();
        wr_en  = 1'b0;
        commit = 1'b0;
        chk_flags("port");
    endtask

    // Full vblank: inject 0 = none, 1 = commit in the vblank_start cycle, 2 = write ch0=7 then.
    task automatic vblank(input int inject);
        bit exp_swap;
        bit was_locked;
        vs = 1'b0;
        for (int k = 1; k <= SS; k++) begin
            tick();
            chk("no_early_swap", DW'(swap_pulse), DW'(0));
        end
        chk("disp_before_swap", disp_data, m_disp);
        was_locked = m_locked;
        exp_swap   = mode || was_locked;
        if (mode) exp_q.push_back(pack_stg());
        if (!mode && !was_locked && m_stale < 32'hFFFF) m_stale++;
        if (inject == 1) begin
            commit = 1'b1;
            if (!mode && !was_locked) begin
                m_locked = 1'b1;
                exp_q.push_back(pack_stg());
            end
        end
        if (inject == 2) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = 10'd7;
            if (mode || !was_locked) stg[0] = 10'd7;
        end
        if (exp_swap) begin
            m_frame++;
            if (!mode) m_locked = 1'b0;
            if (exp_q.size() != 0) m_disp = exp_q.pop_front();
        end
        tick();
        commit = 1'b0;
        wr_en  = 1'b0;
        chk("swap_pulse", DW'(swap_pulse), DW'(exp_swap));
        chk("disp_after_vblank", disp_data, m_disp);
        chk("frame_cnt", DW'(frame_cnt), DW'(m_frame[15:0]));
        chk("stale_cnt", DW'(stale_cnt), DW'(m_stale[15:0]));
        tick();
        chk("swap_one_cycle", DW'(swap_pulse), DW'(0));
        chk_flags("post_vblank");
        vs = 1'b1;
        repeat (SS + 1) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        vs      = 1'b1;
        mode    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        commit  = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_disp", disp_data, {N_CH{IV}});
        chk("rst_swap", DW'(swap_pulse), DW'(0));
        chk("rst_frame", DW'(frame_cnt), DW'(0));
        chk("rst_stale", DW'(stale_cnt), DW'(0));
        chk_flags("rst");

        // Commit-gated transfer; ch15 write shares the commit cycle
        port_cycle(1'b1, 6'd3, 10'd123, 1'b0);
        port_cycle(1'b1, 6'd15, 10'd45, 1'b1);
        port_cycle(1'b1, 6'd3, 10'd999, 1'b0);
        port_cycle(1'b0, '0, '0, 1'b1);
        vblank(0);
        chk("ch3_123", DW'(disp_data[3*W +: W]), DW'(123));
        chk("ch15_45", DW'(disp_data[15*W +: W]), DW'(45));

        // Out-of-range write is dropped
        port_cycle(1'b1, 6'd20, 10'd321, 1'b0);
        port_cycle(1'b0, '0, '0, 1'b1);
        vblank(0);

        // Stale frames, then commit racing vblank_start
        vblank(0);
        vblank(0);
        vblank(0);
        port_cycle(1'b1, 6'd1, 10'd77, 1'b0);
        vblank(1);
        vblank(0);

        // Switching to free-run drops a held lock
        port_cycle(1'b1, 6'd2, 10'd88, 1'b1);
        mode = 1'b1;
        #1;
        m_locked = 1'b0;
        exp_q.delete();
        chk("drop_lock_pending", DW'(pending), DW'(0));
        tick();
        mode = 1'b0;
        tick();
        chk_flags("back_to_0");
        mode = 1'b1;
        tick();

        // Free-run
        port_cycle(1'b0, '0, '0, 1'b1);
        for (int f = 0; f < 4; f++) begin
            port_cycle(1'b1, 6'd0, 10'd5, 1'b0);
            vblank(0);
        end
        vblank(2);
        chk("ch0_stays_5", DW'(disp_data[W-1:0]), DW'(5));
        vblank(0);
        chk("ch0_now_7", DW'(disp_data[W-1:0]), DW'(7));

        // Reset while pending
        mode = 1'b0;
        tick();
        port_cycle(1'b1, 6'd9, 10'd99, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_pending", DW'(pending), DW'(0));
        chk("rst_mid_disp", disp_data, {N_CH{IV}});
        chk("rst_mid_frame", DW'(frame_cnt), DW'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Long vblank yields exactly one swap
        port_cycle(1'b1, 6'd5, 10'd11, 1'b1);
        vs = 1'b0;
        swaps_seen = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (swap_pulse) swaps_seen++;
        end
        m_frame++;
        m_locked = 1'b0;
        if (exp_q.size() != 0) m_disp = exp_q.pop_front();
        chk("long_vs_swaps", DW'(swaps_seen), DW'(1));
        chk("long_vs_disp", disp_data, m_disp);
        chk("long_vs_frame", DW'(frame_cnt), DW'(m_frame[15:0]));
        chk_flags("long_vs");
        vs = 1'b1;
        repeat (SS + 1) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sync_buffer.md
Name: frame_sync_buffer

Overview:
- Generic tear-free transfer buffer between the 60 Hz game-logic data and the VGA pixel path.
- Holds N_CH channels of W-bit values in two banks:
  - Staging bank: written by the producer.
  - Display bank: read by the screen generator.
- Copies staging to display only at the start of vertical blanking.
- Adds over the existing bulk VS-gated copy: explicit commit handshake, free-run mode, a configurable VS synchroniser, and frame/stale statistics.

Parameters:
- N_CH, 16, number of channels (1..64).
- W, 10, bits per channel.
- AW, 6, channel address width; requires 2**AW >= N_CH.
- INIT_VAL, 0, reset value of every staging and display entry (W bits).
- SYNC_STAGES, 2, flops in the vs synchroniser (minimum 2).

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- vs  in  1  raw vertical sync, active-low; not assumed synchronous to clk.
- mode  in  1  0 = commit-gated, 1 = free-run (copy every vblank).
- wr_en  in  1  staging write strobe.
- wr_addr  in  AW  staging channel index.
- wr_data  in  W  staging write data.
- commit  in  1  one-cycle pulse: staging set complete, request swap.
- wr_ready  out  1  staging accepts writes/commit.
- pending  out  1  committed set awaiting vblank.
- disp_data  out  N_CH*W  display bank; channel i occupies bits [i*W +: W].
- swap_pulse  out  1  one-cycle pulse when display bank is updated.
- frame_cnt  out  16  number of swaps, wraps modulo 2**16.
- stale_cnt  out  16  vblanks with nothing committed (mode 0), saturating.

Behaviour:
- Reset (async assert, sync-release use):
  - All staging and display entries = INIT_VAL.
  - Synchroniser flops = 1; edge-detect history = 1.
  - State = OPEN.
  - wr_ready=1, pending=0, swap_pulse=0, frame_cnt=0, stale_cnt=0.
- vs synchronisation:
  - vs passes through a SYNC_STAGES flop chain.
  - vblank_start is a one-cycle internal strobe on the synchronised 1→0 edge.
  - Latency: disp_data and swap_pulse update on the (SYNC_STAGES+1)-th rising edge after the first edge that samples vs=0.
  - vs held low produces exactly one vblank_start.
  - Glitch-free behaviour requires vs low for ≥ 1 clk.
- Writes:
  - Staging[wr_addr] <= wr_data when wr_en && wr_ready && wr_addr < N_CH.
  - Out-of-range addresses are ignored silently.
- Mode 0 state machine:
  - OPEN (wr_ready=1, pending=0): commit → LOCKED. A write in the same cycle as commit is included in the set.
  - OPEN + vblank_start without commit: no copy; stale_cnt += 1, saturating at 0xFFFF.
  - OPEN + commit and vblank_start in the same cycle: go to LOCKED. No swap this frame; the set waits for the next vblank. stale_cnt still increments.
  - LOCKED (wr_ready=0, pending=1): wr_en and commit are ignored.
  - LOCKED + vblank_start: all N_CH entries copied to display in one cycle, swap_pulse=1, frame_cnt += 1 (wrapping), → OPEN.
- Mode 1 (free-run):
  - wr_ready=1 and pending=0 at all times; commit is ignored.
  - Every vblank_start copies staging to display, pulses swap_pulse and increments frame_cnt.
  - A write landing in the same cycle as vblank_start is NOT in that copy; it appears next frame.
  - stale_cnt is frozen.
- Mode change:
  - Sampled every cycle.
  - Switching to 1 while LOCKED drops the lock (→ OPEN) without a copy.
  - Switching 1→0 enters OPEN.
- Display bank:
  - Changes only on swap cycles, so it is stable for the whole active frame.
  - It is registered and driven directly, with no combinational path from the write port.
- Reset mid-frame or mid-lock: everything returns to reset values immediately. A pending set is lost.

Test Plan:
- Reset with N_CH=16, W=10, INIT_VAL=700 → all 16 disp channels = 700, wr_ready=1, pending=0, counters 0.
- Mode 0: write ch3=123, ch15=45, commit, then drop vs → disp ch3=123 and ch15=45 exactly SYNC_STAGES+1 edges after vs sampled low; swap_pulse high 1 cycle; frame_cnt=1; wr_ready back to 1.
- Mode 0 while LOCKED: write ch3=999 → ignored; after swap ch3=123. Write with wr_addr=20 in OPEN → no entry changes.
- Mode 0: three vblanks with no commit → stale_cnt=3, disp unchanged, no swap_pulse. Commit in the same cycle as vblank_start → pending=1, swap on the following vblank only.
- Mode 1: write ch0=5 each frame, 4 vblanks → frame_cnt=4 and commit ignored. Write ch0=7 in the exact vblank_start cycle → disp ch0 stays 5 until the next vblank.
- Reset asserted while pending=1 → immediately pending=0, disp=INIT_VAL. vs held low 1000 cycles → exactly one swap.
